axi_qspi_queue: RTL and testbench
=================================

AXI_QSPI_QUEUE -- requirements
Module: axi_qspi_queue

Interface
REQ-001 Parameter AW, default 8, AXI4-Lite address width in bits.
REQ-002 Parameter DEPTH, default 8, entries in each of the command FIFO and the result FIFO; power of two, 2..64.
REQ-003 Parameter RDW, default 64, QSPI read/write data width; multiple of 32, 32..128.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 resetn  in  1  reset: synchronous, active-low.
REQ-006 S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave ports, 32-bit data, AW-bit address, standard directions and widths; PROT inputs ignored.
REQ-007 qspi_cmd  out  8  QSPI opcode of the command being issued.
REQ-008 qspi_bankmap  out  8  flash bank-select mask.
REQ-009 qspi_addr  out  32  flash address.
REQ-010 qspi_wdata  out  RDW  write payload.
REQ-011 qspi_start  out  1  one-cycle launch strobe.
REQ-012 qspi_idle  in  1  1 = QSPI engine idle.
REQ-013 qspi_rdata  in  RDW  read data; valid when qspi_idle rises after a start.

Function
REQ-014 Register indices (32-bit words): 0 CMD, 1 BANKMAP, 2 ADDR, 3..(2+RDW/32) WDATA (MS word first) form a staging record; the block SHALL return each written value on read.
REQ-015 PUSH (index 8), write with bit0=1: copy the staging record into the command FIFO; FIFO full -> no push, BRESP SLVERR, sticky STATUS.ovf set.
REQ-016 RDATA (indices 9..(8+RDW/32), MS word first): read the head result; a read of the last (LS) word pops it; result FIFO empty -> RDATA 0, RRESP SLVERR, no pop.
REQ-017 STATUS (index 16), read-only: [7:0] command count, [15:8] result count, [16] dispatcher busy, [17] ovf, [18] udf (sticky, set on empty-pop).
REQ-018 CLEAR (index 17), write with bit0=1: flush both FIFOs and clear ovf/udf; an in-flight command completes, but its result is discarded.
REQ-019 Any other index SHALL return DECERR on read and on write; register writes SHALL ignore WSTRB.
REQ-020 Dispatcher FSM SHALL have four states: IDLE -> LAUNCH when the command FIFO is non-empty and qspi_idle=1; LAUNCH drives the head fields, pulses qspi_start for 1 cycle, pops, -> WAIT; WAIT -> STORE on the first cycle qspi_idle=1 after at least one cycle in WAIT; STORE pushes qspi_rdata -> IDLE; if the result FIFO is full, STORE stalls (no command loss, no result overwrite).
REQ-021 qspi_* outputs SHALL hold the last launched values until the next LAUNCH.
REQ-022 A PUSH coinciding with a dispatcher pop SHALL both take effect; count is unchanged when full-1 or when count is exact.
REQ-023 Latency: PUSH write into an empty queue with qspi_idle=1 -> qspi_start within 3 clk of the W handshake.
REQ-024 AXI write and read paths are independent; B/R responses SHALL be issued one per request, in order.

Reset
REQ-025 On resetn=0: FIFOs empty; FSM IDLE; qspi_start=0; qspi_cmd/bankmap/addr/wdata=0; staging record=0; ovf=udf=0; BVALID=RVALID=0; AWREADY=WREADY=ARREADY=0.
REQ-026 Reset mid-command SHALL abandon the command with no result stored and no further qspi_start.

Configuration
REQ-027 Macro AXI_QSPI_QUEUE_IRQ_EN: when defined, add output irq (1 bit), registered, high while the result count is non-zero or ovf=1, reset 0; when undefined, there is no irq port and no logic.

Structure
REQ-028 A shared package (qspi_queue_pkg) SHALL hold the register-index constants, the STATUS bit positions, the FSM state encoding and the command-record field widths.
REQ-029 One sub-module, qspi_sync_fifo (parameters WIDTH, DEPTH; count output; flush input), instantiated twice; the AXI4-Lite front end is the team's standard axi4_lite_slave core.

Verification
REQ-030 Stage CMD=0x0B, ADDR=0x1000, PUSH; model returns rdata 0x1122334455667788 after 5 clk -> one qspi_start; RDATA reads 0x11223344, 0x55667788; STATUS[15:8]=0 afterwards.
REQ-031 With the model held busy, push DEPTH+1 commands -> the first DEPTH return OKAY, the last SLVERR; STATUS.ovf=1; after release, exactly DEPTH starts, issued in push order.
REQ-032 Read RDATA LS word with the result FIFO empty -> SLVERR, data 0, udf=1; then CLEAR -> udf=0, counts 0.
REQ-033 Fill the result FIFO (DEPTH results unread) with 2 commands queued -> FSM stalls in STORE, no third start; one RDATA pop -> the stalled result is stored, and the next start follows.
REQ-034 Assert resetn=0 in WAIT, then release -> no result stored, qspi_start stays 0, STATUS=0.
REQ-035 With AXI_QSPI_QUEUE_IRQ_EN defined: irq rises 1 clk after the first result is stored and falls after the last pop.

Source files
------------

// File: rtl/qspi_queue_pkg.sv
// Shared definitions for the AXI4-Lite QSPI command queue: register word
// indices, STATUS bit positions, AXI response codes, command-record field
// widths and the dispatcher state encoding.
package qspi_queue_pkg;

  // Register word indices (byte address = index * 4)
  localparam int IDX_CMD     = 0;
  localparam int IDX_BANKMAP = 1;
  localparam int IDX_ADDR    = 2;
  localparam int IDX_WDATA   = 3;   // first (most significant) payload word
  localparam int IDX_PUSH    = 8;
  localparam int IDX_RDATA   = 9;   // first (most significant) result word
  localparam int IDX_STATUS  = 16;
  localparam int IDX_CLEAR   = 17;

  // STATUS bit positions
  localparam int STAT_CMD_LSB = 0;
  localparam int STAT_RES_LSB = 8;
  localparam int STAT_BUSY    = 16;
  localparam int STAT_OVF     = 17;
  localparam int STAT_UDF     = 18;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Command-record field widths; the payload width is the RDW parameter
  localparam int CMD_W  = 8;
  localparam int BANK_W = 8;
  localparam int ADDR_W = 32;

  // Dispatcher states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_STORE  = 2'd3
  } dsp_state_e;

  // Width of one queued command record: {cmd, bankmap, addr, wdata}
  function automatic int rec_width(input int rdw);
    return CMD_W + BANK_W + ADDR_W + rdw;
  endfunction

endpackage

// File: rtl/axi_qspi_queue_if.sv
// AXI4-Lite bus bundle for the QSPI command queue.
// Handshake: a transfer happens on a rising clk edge where VALID and READY
// are both 1; a source holds VALID and its payload stable until that edge
// and never waits for READY before raising VALID.
interface axi_qspi_queue_if #(parameter int AW = 8) ();
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/qspi_sync_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
// Push while full and pop while empty are ignored; flush wins over both.
module qspi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/axi_qspi_queue.sv
// AXI4-Lite programmed QSPI command queue: staging registers build a command
// record, PUSH queues it, a four-state dispatcher launches commands on the
// QSPI engine and queues their read data for RDATA reads.
// Optional build macro AXI_QSPI_QUEUE_IRQ_EN adds a registered irq output.
module axi_qspi_queue
  import qspi_queue_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 8,
  parameter int RDW   = 64
) (
  input  logic                clk,
  input  logic                resetn,
  axi_qspi_queue_if.slave     s_axi,
  output logic [CMD_W-1:0]    qspi_cmd,
  output logic [BANK_W-1:0]   qspi_bankmap,
  output logic [ADDR_W-1:0]   qspi_addr,
  output logic [RDW-1:0]      qspi_wdata,
  output logic                qspi_start,
  input  logic                qspi_idle,
  input  logic [RDW-1:0]      qspi_rdata,
  output dsp_state_e          dbg_state
`ifdef AXI_QSPI_QUEUE_IRQ_EN
  ,
  output logic                irq
`endif
);
  localparam int NW   = RDW / 32;
  localparam int RECW = rec_width(RDW);
  localparam int CW   = $clog2(DEPTH) + 1;

  // AXI channel state
  logic        wr_ready_q, bvalid_q, rd_ready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        wr_fire, rd_fire;
  logic [31:0] aw_idx, ar_idx;

  // Staging record and sticky flags
  logic [31:0] stg_cmd, stg_bank, stg_addr;
  logic [31:0] stg_wdata [NW];
  logic        ovf_q, udf_q;

  // Decode results
  logic [1:0]  wr_resp, rd_resp;
  logic        wr_hit, push_req, clear_req;
  logic        rd_hit, rd_pop, rd_udf;
  logic [31:0] rd_data, status_word;

  // FIFO and dispatcher signals
  logic [RECW-1:0] cmd_rec, cmd_head;
  logic [RDW-1:0]  res_head;
  logic            cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic            res_push, res_pop, res_full, res_empty;
  logic [CW-1:0]   cmd_count, res_count;
  logic            clear_p;
  dsp_state_e      state, state_nx;
  logic            waited_q, discard_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.wstrb,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = wr_ready_q;
  assign s_axi.wready  = wr_ready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = rd_ready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign wr_fire  = wr_ready_q && s_axi.awvalid && s_axi.wvalid;
  assign rd_fire  = rd_ready_q && s_axi.arvalid;
  assign aw_idx   = 32'(s_axi.awaddr[AW-1:2]);
  assign ar_idx   = 32'(s_axi.araddr[AW-1:2]);
  assign cmd_push = wr_fire && push_req;
  assign clear_p  = wr_fire && clear_req;
  assign res_pop  = rd_fire && rd_pop;

  assign status_word = {13'd0, udf_q, ovf_q, (state != S_IDLE),
                        8'(res_count), 8'(cmd_count)};

  // Write decode: response and side effects of the addressed register
  always_comb begin
    wr_resp   = RESP_OKAY;
    wr_hit    = 1'b0;
    push_req  = 1'b0;
    clear_req = 1'b0;
    if (aw_idx == IDX_CMD || aw_idx == IDX_BANKMAP || aw_idx == IDX_ADDR ||
        aw_idx == IDX_STATUS) begin
      wr_hit = 1'b1;
    end else if (aw_idx == IDX_PUSH) begin
      wr_hit = 1'b1;
      if (s_axi.wdata[0]) begin
        if (cmd_full) wr_resp  = RESP_SLVERR;
        else          push_req = 1'b1;
      end
    end else if (aw_idx == IDX_CLEAR) begin
      wr_hit    = 1'b1;
      clear_req = s_axi.wdata[0];
    end
    for (int k = 0; k < NW; k++) begin
      if (aw_idx == 32'(IDX_WDATA + k) || aw_idx == 32'(IDX_RDATA + k)) wr_hit = 1'b1;
    end
    if (!wr_hit) wr_resp = RESP_DECERR;
  end

  // Read decode: data, response, result pop and underflow detection
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    rd_hit  = 1'b0;
    rd_pop  = 1'b0;
    rd_udf  = 1'b0;
    if (ar_idx == IDX_CMD) begin
      rd_hit = 1'b1; rd_data = stg_cmd;
    end else if (ar_idx == IDX_BANKMAP) begin
      rd_hit = 1'b1; rd_data = stg_bank;
    end else if (ar_idx == IDX_ADDR) begin
      rd_hit = 1'b1; rd_data = stg_addr;
    end else if (ar_idx == IDX_STATUS) begin
      rd_hit = 1'b1; rd_data = status_word;
    end else if (ar_idx == IDX_PUSH || ar_idx == IDX_CLEAR) begin
      rd_hit = 1'b1;
    end
    for (int k = 0; k < NW; k++) begin
      if (ar_idx == 32'(IDX_WDATA + k)) begin
        rd_hit  = 1'b1;
        rd_data = stg_wdata[k];
      end
      if (ar_idx == 32'(IDX_RDATA + k)) begin
        rd_hit = 1'b1;
        if (res_empty) begin
          rd_resp = RESP_SLVERR;
          rd_udf  = (k == NW - 1);
        end else begin
          rd_data = res_head[RDW-1-32*k -: 32];
          rd_pop  = (k == NW - 1);
        end
      end
    end
    if (!rd_hit) rd_resp = RESP_DECERR;
  end

  // Write channel: single-cycle ready once AW and W are both offered, then B
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_ready_q <= !wr_ready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: single-cycle ready per AR, data registered into R
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      rd_ready_q <= !rd_ready_q && s_axi.arvalid && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_resp;
        rdata_q  <= rd_data;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Staging registers take the full 32-bit word regardless of WSTRB
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stg_cmd  <= '0;
      stg_bank <= '0;
      stg_addr <= '0;
      for (int k = 0; k < NW; k++) stg_wdata[k] <= '0;
    end else if (wr_fire) begin
      if (aw_idx == IDX_CMD)     stg_cmd  <= s_axi.wdata;
      if (aw_idx == IDX_BANKMAP) stg_bank <= s_axi.wdata;
      if (aw_idx == IDX_ADDR)    stg_addr <= s_axi.wdata;
      for (int k = 0; k < NW; k++) begin
        if (aw_idx == 32'(IDX_WDATA + k)) stg_wdata[k] <= s_axi.wdata;
      end
    end
  end

  // Sticky error flags; CLEAR takes priority over a coincident set
  always_ff @(posedge clk) begin
    if (!resetn || clear_p) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_fire && wr_resp == RESP_SLVERR) ovf_q <= 1'b1;
      if (rd_fire && rd_udf)                 udf_q <= 1'b1;
    end
  end

  // Staging record flattened MS word first behind cmd/bankmap/addr
  always_comb begin
    cmd_rec = '0;
    cmd_rec[RECW-1 -: CMD_W]              = stg_cmd[CMD_W-1:0];
    cmd_rec[RECW-CMD_W-1 -: BANK_W]       = stg_bank[BANK_W-1:0];
    cmd_rec[RDW+ADDR_W-1 -: ADDR_W]       = stg_addr;
    for (int k = 0; k < NW; k++) cmd_rec[RDW-1-32*k -: 32] = stg_wdata[k];
  end

  qspi_sync_fifo #(.WIDTH(RECW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(clk), .resetn(resetn), .flush(clear_p),
    .push(cmd_push), .wdata(cmd_rec), .pop(cmd_pop), .rdata(cmd_head),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );

  qspi_sync_fifo #(.WIDTH(RDW), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .resetn(resetn), .flush(clear_p),
    .push(res_push), .wdata(qspi_rdata), .pop(res_pop), .rdata(res_head),
    .full(res_full), .empty(res_empty), .count(res_count)
  );

  // Dispatcher next state; a launch is held off in the CLEAR cycle because
  // the head it would pop is being flushed
  always_comb begin
    state_nx = state;
    cmd_pop  = 1'b0;
    res_push = 1'b0;
    case (state)
      S_IDLE:   if (!cmd_empty && qspi_idle && !clear_p) state_nx = S_LAUNCH;
      S_LAUNCH: begin
        cmd_pop  = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT:   if (waited_q && qspi_idle) state_nx = S_STORE;
      S_STORE: begin
        if (discard_q) begin
          state_nx = S_IDLE;
        end else if (!res_full) begin
          res_push = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // Dispatcher state, WAIT dwell marker and discard-after-CLEAR marker
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      waited_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state     <= state_nx;
      waited_q  <= (state == S_WAIT);
      discard_q <= (state_nx != S_IDLE) && (discard_q || (clear_p && state != S_IDLE));
    end
  end

  // QSPI launch outputs: fields captured on entry to LAUNCH and held until the next one
  always_ff @(posedge clk) begin
    if (!resetn) begin
      qspi_start   <= 1'b0;
      qspi_cmd     <= '0;
      qspi_bankmap <= '0;
      qspi_addr    <= '0;
      qspi_wdata   <= '0;
    end else begin
      qspi_start <= (state == S_IDLE) && (state_nx == S_LAUNCH);
      if (state == S_IDLE && state_nx == S_LAUNCH) begin
        qspi_cmd     <= cmd_head[RECW-1 -: CMD_W];
        qspi_bankmap <= cmd_head[RECW-CMD_W-1 -: BANK_W];
        qspi_addr    <= cmd_head[RDW+ADDR_W-1 -: ADDR_W];
        qspi_wdata   <= cmd_head[RDW-1:0];
      end
    end
  end

  assign dbg_state = state;

`ifdef AXI_QSPI_QUEUE_IRQ_EN
  // Interrupt level: results waiting or an overflow has been recorded
  always_ff @(posedge clk) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= (res_count != '0) || ovf_q;
  end
`endif

endmodule

// File: tb/tb_axi_qspi_queue.sv
// Directed bench for axi_qspi_queue: AXI driver tasks, a behavioural QSPI
// engine, and monitors that pop expected B/R responses and launches from
// queues as the DUT presents them.
`timescale 1ns/1ps
module tb_axi_qspi_queue;
  import qspi_queue_pkg::*;

  localparam int AW = 8, DEPTH = 8, RDW = 64;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_qspi_queue_if #(.AW(AW)) s_axi ();
  logic [7:0]     qspi_cmd, qspi_bankmap;
  logic [31:0]    qspi_addr;
  logic [RDW-1:0] qspi_wdata;
  logic           qspi_start;
  logic           qspi_idle = 1'b1;
  logic [RDW-1:0] qspi_rdata = '0;
  dsp_state_e     dbg_state;
`ifdef AXI_QSPI_QUEUE_IRQ_EN
  logic           irq;
`endif

  axi_qspi_queue #(.AW(AW), .DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk(clk), .resetn(resetn), .s_axi(s_axi),
    .qspi_cmd(qspi_cmd), .qspi_bankmap(qspi_bankmap), .qspi_addr(qspi_addr),
    .qspi_wdata(qspi_wdata), .qspi_start(qspi_start), .qspi_idle(qspi_idle),
    .qspi_rdata(qspi_rdata), .dbg_state(dbg_state)
`ifdef AXI_QSPI_QUEUE_IRQ_EN
    , .irq(irq)
`endif
  );

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [1:0]   exp_b_q[$];
  logic [33:0]  exp_r_q[$];
  logic [111:0] exp_s_q[$];
  logic [63:0]  model_rdata_q[$];
  int   model_delay = 5;
  logic model_hold = 1'b0;
  int   model_cnt = 0;
  logic [7:0]  tb_cmd  = 8'h0B;
  logic [7:0]  tb_bank = 8'h03;
  logic [63:0] tb_wdata = 64'hDEADBEEF_01234567;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: one AXI write, expected BRESP queued first
  task automatic axi_write(input int idx, input logic [31:0] data, input logic [1:0] resp);
    int n;
    exp_b_q.push_back(resp);
    @(negedge clk);
    s_axi.awaddr = AW'(idx * 4); s_axi.wdata = data; s_axi.wstrb = 4'h0;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi.awready) begin
      vectors++; miscompares++;
      $display("FAIL aw_handshake: no awready within 20 cycles (idx %0d)", idx);
      void'(exp_b_q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
  endtask

  // driver: one AXI read, expected {RRESP,RDATA} queued first
  task automatic axi_read(input int idx, input logic [31:0] data, input logic [1:0] resp);
    int n;
    exp_r_q.push_back({resp, data});
    @(negedge clk);
    s_axi.araddr = AW'(idx * 4); s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < 20) begin @(negedge clk); n++; end
    if (!s_axi.arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_handshake: no arready within 20 cycles (idx %0d)", idx);
      void'(exp_r_q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1;
    s_axi.arvalid = 1'b0;
    wait_clk(2);
  endtask

  // stage ADDR then PUSH; a successful push also predicts its launch
  task automatic push_cmd(input logic [31:0] addr, input logic [1:0] resp, input bit launches);
    axi_write(IDX_ADDR, addr, RESP_OKAY);
    if (launches) exp_s_q.push_back({tb_cmd, tb_bank, addr, tb_wdata});
    axi_write(IDX_PUSH, 32'h1, resp);
  endtask

  // monitors: B, R and launch strobes
  initial begin
    forever begin
      @(negedge clk);
      if (s_axi.bvalid) begin
        if (exp_b_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL bresp: unexpected response %0h", s_axi.bresp);
        end else check("bresp", 128'(s_axi.bresp), 128'(exp_b_q.pop_front()));
      end
      if (s_axi.rvalid) begin
        if (exp_r_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rresp_rdata: unexpected response %0h", {s_axi.rresp, s_axi.rdata});
        end else check("rresp_rdata", 128'({s_axi.rresp, s_axi.rdata}), 128'(exp_r_q.pop_front()));
      end
      if (qspi_start) begin
        if (exp_s_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL qspi_launch: unexpected start addr %0h", qspi_addr);
        end else check("qspi_launch", 128'({qspi_cmd, qspi_bankmap, qspi_addr, qspi_wdata}),
                       128'(exp_s_q.pop_front()));
      end
    end
  end

  // behavioural QSPI engine: busy for model_delay cycles after each start
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) model_cnt = 0;
      else if (qspi_start) begin
        model_cnt = model_delay;
        if (model_rdata_q.size() > 0) qspi_rdata = model_rdata_q.pop_front();
      end else if (model_cnt > 0) model_cnt--;
      qspi_idle = (model_cnt == 0) && !model_hold;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_found;
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;

    // reset state
    wait_clk(4);
    check("reset_awready", 128'(s_axi.awready), 0);
    check("reset_arready", 128'(s_axi.arready), 0);
    check("reset_bvalid",  128'(s_axi.bvalid), 0);
    check("reset_rvalid",  128'(s_axi.rvalid), 0);
    check("reset_start",   128'(qspi_start), 0);
    check("reset_fields",  128'({qspi_cmd, qspi_bankmap, qspi_addr, qspi_wdata}), 0);
    resetn = 1'b1;
    wait_clk(2);
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);

    // register readback (WSTRB driven 0 and ignored) and decode errors
    axi_write(IDX_CMD, 32'hA5A5_000B, RESP_OKAY);
    axi_write(IDX_BANKMAP, 32'h1234_5603, RESP_OKAY);
    axi_write(IDX_ADDR, 32'hCAFE_F00D, RESP_OKAY);
    axi_write(3, 32'hDEAD_BEEF, RESP_OKAY);
    axi_write(4, 32'h0123_4567, RESP_OKAY);
    axi_read(IDX_CMD, 32'hA5A5_000B, RESP_OKAY);
    axi_read(IDX_BANKMAP, 32'h1234_5603, RESP_OKAY);
    axi_read(IDX_ADDR, 32'hCAFE_F00D, RESP_OKAY);
    axi_read(3, 32'hDEAD_BEEF, RESP_OKAY);
    axi_read(4, 32'h0123_4567, RESP_OKAY);
    axi_read(7, 32'h0, RESP_DECERR);
    axi_read(20, 32'h0, RESP_DECERR);
    axi_write(20, 32'h1, RESP_DECERR);

    // single command round trip with launch latency
    axi_write(IDX_CMD, 32'h0000_000B, RESP_OKAY);
    axi_write(IDX_BANKMAP, 32'h0000_0003, RESP_OKAY);
    model_delay = 5;
    model_rdata_q.push_back(64'h1122_3344_5566_7788);
    axi_write(IDX_ADDR, 32'h1000, RESP_OKAY);
    exp_s_q.push_back({tb_cmd, tb_bank, 32'h1000, tb_wdata});
    axi_write(IDX_PUSH, 32'h1, RESP_OKAY);
    lat_found = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (qspi_start) lat_found = 1;
    end
    check("push_to_start_latency", 128'(lat_found), 1);
    wait_clk(12);
`ifdef AXI_QSPI_QUEUE_IRQ_EN
    check("irq_after_store", 128'(irq), 1);
`endif
    axi_read(9, 32'h1122_3344, RESP_OKAY);
    axi_read(10, 32'h5566_7788, RESP_OKAY);
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);
`ifdef AXI_QSPI_QUEUE_IRQ_EN
    check("irq_after_pop", 128'(irq), 0);
`endif
    check("fields_held", 128'(qspi_addr), 128'(32'h1000));

    // underflow then CLEAR
    axi_read(10, 32'h0, RESP_SLVERR);
    axi_read(IDX_STATUS, 32'h0004_0000, RESP_OKAY);
    axi_write(IDX_CLEAR, 32'h1, RESP_OKAY);
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);

    // overflow with engine held busy, then ordered drain
    tb_cmd = 8'h3B; tb_bank = 8'h01;
    axi_write(IDX_CMD, 32'h3B, RESP_OKAY);
    axi_write(IDX_BANKMAP, 32'h01, RESP_OKAY);
    model_hold = 1'b1;
    wait_clk(2);
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) model_rdata_q.push_back({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
      push_cmd(32'h2000 + 32'(i), (i < DEPTH) ? RESP_OKAY : RESP_SLVERR, i < DEPTH);
    end
    axi_read(IDX_STATUS, 32'h0002_0008, RESP_OKAY);
    model_delay = 2;
    model_hold = 1'b0;
    wait_clk(100);
    axi_read(IDX_STATUS, 32'h0002_0800, RESP_OKAY);
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(9, 32'hA000_0000 + 32'(i), RESP_OKAY);
      axi_read(10, 32'hB000_0000 + 32'(i), RESP_OKAY);
    end
    axi_write(IDX_CLEAR, 32'h1, RESP_OKAY);
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);

    // result FIFO full: STORE stalls until one pop, CLEAR discards the in-flight result
    model_delay = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      model_rdata_q.push_back({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
      push_cmd(32'h3000 + 32'(i), RESP_OKAY, 1'b1);
    end
    wait_clk(60);
    check("stall_state", 128'(dbg_state), 128'(S_STORE));
    axi_read(IDX_STATUS, 32'h0001_0801, RESP_OKAY);
    axi_read(9, 32'hC000_0000, RESP_OKAY);
    axi_read(10, 32'hD000_0000, RESP_OKAY);
    wait_clk(30);
    axi_read(IDX_STATUS, 32'h0001_0800, RESP_OKAY);
    check("stall_state_again", 128'(dbg_state), 128'(S_STORE));
    axi_write(IDX_CLEAR, 32'h1, RESP_OKAY);
    wait_clk(3);
    check("clear_discard_state", 128'(dbg_state), 128'(S_IDLE));
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);

    // reset while the command is in WAIT
    model_delay = 20;
    model_rdata_q.push_back(64'hEEEE_EEEE_EEEE_EEEE);
    push_cmd(32'h4000, RESP_OKAY, 1'b1);
    wait_clk(6);
    check("wait_before_reset", 128'(dbg_state), 128'(S_WAIT));
    resetn = 1'b0;
    wait_clk(3);
    check("reset_mid_state", 128'(dbg_state), 128'(S_IDLE));
    check("reset_mid_fields", 128'({qspi_cmd, qspi_addr}), 0);
    resetn = 1'b1;
    wait_clk(40);
    axi_read(IDX_STATUS, 32'h0, RESP_OKAY);
    axi_read(IDX_CMD, 32'h0, RESP_OKAY);

    // everything predicted must have been observed
    wait_clk(10);
    check("pending_b",      128'(exp_b_q.size()), 0);
    check("pending_r",      128'(exp_r_q.size()), 0);
    check("pending_starts", 128'(exp_s_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
